// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI read sequencer and its clock generator.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    CMD,
    RD,
    CS_HOLD,
    FIN
  } spi_state_t;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [7:0] CS_IDLE   = 8'hFF;

  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

endpackage

// File: rtl/spi_rd_seq_master_if.sv
// Request, serial and buffer-side signals of the SPI read sequencer.
interface spi_rd_seq_master_if;

  logic       start;
  logic [7:0] spi_select_in;
  logic [7:0] spi_reg_in;
  logic       miso;
  logic       sclk;
  logic       mosi;
  logic [7:0] cs_n;
  logic       busy;
  logic       done;
  logic       err_sel;
  logic       buffer_en;
  logic [4:0] addr;
  logic [7:0] data_rec_out;
  logic [7:0] spi_select;
  logic [7:0] spi_reg;

  modport master (
    input  start, spi_select_in, spi_reg_in, miso,
    output sclk, mosi, cs_n, busy, done, err_sel,
    output buffer_en, addr, data_rec_out, spi_select, spi_reg
  );

  modport slave (
    output start, spi_select_in, spi_reg_in, miso,
    input  sclk, mosi, cs_n, busy, done, err_sel,
    input  buffer_en, addr, data_rec_out, spi_select, spi_reg
  );

endinterface

// File: rtl/spi_clk_gen.sv
// SCLK divider: each level lasts CLK_DIV cycles; ticks flag the edge on which sclk toggles.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam int            CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic          SCLK_IDLE = SPI_MODE0[1];

  logic [CW-1:0] cnt_q;
  logic          sclk_q;
  logic          phase_end;

  assign phase_end   = en_i && (cnt_q == CNT_LAST);
  assign rise_tick_o = phase_end && (sclk_q == SCLK_IDLE);
  assign fall_tick_o = phase_end && (sclk_q != SCLK_IDLE);
  assign sclk_o      = sclk_q;

  // Disabling restarts the divider so every enable begins with a full idle-level phase.
  always_ff @(posedge clk) begin
    if (rst || !en_i) begin
      cnt_q  <= '0;
      sclk_q <= SCLK_IDLE;
    end else if (phase_end) begin
      cnt_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/spi_rd_seq_master.sv
// SPI mode-0 master: sends one command byte, then reads N_BYTES and strobes each into the receive buffer.
module spi_rd_seq_master
  import spi_pkg::*;
#(
  parameter int         CLK_DIV    = 4,
  parameter int         N_BYTES    = 5,
  parameter logic [4:0] FIRST_ADDR = 5'd3
) (
  input logic                 clk,
  input logic                 rst,
  spi_rd_seq_master_if.master spi_if
);

  localparam int            CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [2:0]    LAST_BYTE = 3'(N_BYTES - 1);

  spi_state_t    state_q;
  logic [CW-1:0] div_q;
  logic [2:0]    bit_q;
  logic [2:0]    byte_q;
  logic [7:0]    tx_q;
  logic [7:0]    rx_q;
  logic [7:0]    rx_d;
  logic          mosi_q;
  logic [7:0]    cs_n_q;
  logic          busy_q;
  logic          done_q;
  logic          err_sel_q;
  logic          buffer_en_q;
  logic [4:0]    addr_q;
  logic [7:0]    data_q;
  logic [7:0]    sel_q;
  logic [7:0]    reg_q;
  logic          sclk;
  logic          rise_tick;
  logic          fall_tick;
  logic          clk_en;

  assign clk_en = (state_q == CMD) || (state_q == RD);
  assign rx_d   = {rx_q[6:0], spi_if.miso};

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk         (clk),
    .rst         (rst),
    .en_i        (clk_en),
    .sclk_o      (sclk),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      mosi_q      <= 1'b0;
      cs_n_q      <= CS_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_sel_q   <= 1'b0;
      buffer_en_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      sel_q       <= '0;
      reg_q       <= '0;
    end else begin
      done_q      <= 1'b0;
      err_sel_q   <= 1'b0;
      buffer_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (spi_if.start) begin
            if (is_onehot8(spi_if.spi_select_in)) begin
              sel_q   <= spi_if.spi_select_in;
              reg_q   <= spi_if.spi_reg_in;
              tx_q    <= spi_if.spi_reg_in;
              mosi_q  <= spi_if.spi_reg_in[7];
              cs_n_q  <= ~spi_if.spi_select_in;
              busy_q  <= 1'b1;
              div_q   <= '0;
              bit_q   <= '0;
              byte_q  <= '0;
              addr_q  <= '0;
              data_q  <= '0;
              state_q <= CS_SETUP;
            end else begin
              err_sel_q <= 1'b1;
            end
          end
        end
        CS_SETUP: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            mosi_q  <= tx_q[7];
            state_q <= CMD;
          end else begin
            div_q <= div_q + CW'(1);
          end
        end
        CMD: begin
          // mosi only moves on falling edges, so it is stable across every rising edge.
          if (fall_tick) begin
            if (bit_q == 3'd7) begin
              bit_q   <= '0;
              mosi_q  <= 1'b0;
              state_q <= RD;
            end else begin
              bit_q  <= bit_q + 3'd1;
              tx_q   <= {tx_q[6:0], 1'b0};
              mosi_q <= tx_q[6];
            end
          end
        end
        RD: begin
          if (rise_tick) begin
            rx_q <= rx_d;
            if (bit_q == 3'd7) begin
              data_q      <= rx_d;
              addr_q      <= FIRST_ADDR + {2'b00, byte_q};
              buffer_en_q <= 1'b1;
            end
          end
          if (fall_tick) begin
            if (bit_q == 3'd7) begin
              bit_q <= '0;
              if (byte_q == LAST_BYTE) begin
                state_q <= CS_HOLD;
              end else begin
                byte_q <= byte_q + 3'd1;
              end
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end
        end
        CS_HOLD: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            cs_n_q  <= CS_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            div_q <= div_q + CW'(1);
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign spi_if.sclk         = sclk;
  assign spi_if.mosi         = mosi_q;
  assign spi_if.cs_n         = cs_n_q;
  assign spi_if.busy         = busy_q;
  assign spi_if.done         = done_q;
  assign spi_if.err_sel      = err_sel_q;
  assign spi_if.buffer_en    = buffer_en_q;
  assign spi_if.addr         = addr_q;
  assign spi_if.data_rec_out = data_q;
  assign spi_if.spi_select   = sel_q;
  assign spi_if.spi_reg      = reg_q;

endmodule

// File: tb/tb_spi_rd_seq_master.sv
// Directed bench for spi_rd_seq_master: default instance plus an N_BYTES=1 instance for timing.
module tb_spi_rd_seq_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  logic [7:0] slv_data [0:4];
  logic [7:0] slv1_data;
  int         slv_rises = 0;
  int         slv_k;
  int         slv1_rises = 0;
  int         slv1_k;
  logic [4:0] cap_addr [0:7];
  logic [7:0] cap_data [0:7];

  spi_rd_seq_master_if bus ();
  spi_rd_seq_master_if bus1 ();

  always #5 clk = ~clk;

  spi_rd_seq_master #(.CLK_DIV(4), .N_BYTES(5), .FIRST_ADDR(5'd3)) dut (
    .clk    (clk),
    .rst    (rst),
    .spi_if (bus)
  );

  spi_rd_seq_master #(.CLK_DIV(4), .N_BYTES(1), .FIRST_ADDR(5'd3)) dut1 (
    .clk    (clk),
    .rst    (rst),
    .spi_if (bus1)
  );

  // Mode-0 slave: after the 8 command bits, shift read bytes out MSB first on each sclk fall.
  always @(bus.sclk or bus.cs_n) begin
    if (bus.cs_n == 8'hFF) begin
      slv_rises = 0;
      bus.miso  = 1'b0;
    end else if (bus.sclk) begin
      slv_rises = slv_rises + 1;
    end else begin
      slv_k = slv_rises - 8;
      if (slv_k >= 0 && slv_k < 40) bus.miso = slv_data[slv_k[5:3]][~slv_k[2:0]];
      else bus.miso = 1'b0;
    end
  end

  always @(bus1.sclk or bus1.cs_n) begin
    if (bus1.cs_n == 8'hFF) begin
      slv1_rises = 0;
      bus1.miso  = 1'b0;
    end else if (bus1.sclk) begin
      slv1_rises = slv1_rises + 1;
    end else begin
      slv1_k = slv1_rises - 8;
      if (slv1_k >= 0 && slv1_k < 8) bus1.miso = slv1_data[~slv1_k[2:0]];
      else bus1.miso = 1'b0;
    end
  end

  // Runs one transaction on the default instance and collects what it observes; no checking here.
  task automatic run_txn(input logic [7:0] sel, input logic [7:0] rg, input int inject_at,
                         output int done_n, output logic [7:0] cmd, output int cs_bad,
                         output int nstb);
    int   n;
    int   rises;
    logic prev_sclk;
    done_n = 0; cmd = 8'h00; cs_bad = 0; nstb = 0; rises = 0; prev_sclk = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cap_addr[i] = 5'd0;
      cap_data[i] = 8'h00;
    end
    @(negedge clk);
    bus.spi_select_in = sel;
    bus.spi_reg_in    = rg;
    bus.start         = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (done_n == 0 && n <= 600) begin
      if (bus.done === 1'b1) begin
        done_n = n;
      end else begin
        if (bus.busy === 1'b1 && bus.cs_n !== ~sel) cs_bad++;
        if (bus.sclk === 1'b1 && prev_sclk === 1'b0) begin
          if (rises < 8) cmd = {cmd[6:0], bus.mosi};
          rises++;
        end
        if (bus.buffer_en === 1'b1) begin
          if (nstb < 8) begin
            cap_addr[nstb] = bus.addr;
            cap_data[nstb] = bus.data_rec_out;
          end
          nstb++;
        end
        prev_sclk = bus.sclk;
        if (n == inject_at) begin
          bus.spi_select_in = 8'h01;
          bus.spi_reg_in    = 8'h55;
          bus.start         = 1'b1;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        n++;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({bus.done, bus.err_sel, bus.buffer_en, bus.mosi, bus.spi_select, bus.spi_reg} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_regs: done=%b err_sel=%b buffer_en=%b mosi=%b spi_select=%h spi_reg=%h, want all 0",
               bus.done, bus.err_sel, bus.buffer_en, bus.mosi, bus.spi_select, bus.spi_reg);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.cs_n, bus.sclk, bus.busy, bus.addr, bus.data_rec_out} !==
          {8'hFF, 1'b0, 1'b0, 5'd0, 8'h00}) begin
        miscompares++;
        $display("FAIL reset_idle cycle %0d: cs_n=%h sclk=%b busy=%b addr=%0d data=%h, want ff 0 0 0 00",
                 i, bus.cs_n, bus.sclk, bus.busy, bus.addr, bus.data_rec_out);
      end
    end
    vectors++;
    if ({bus1.cs_n, bus1.sclk, bus1.busy} !== {8'hFF, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_idle_n1: cs_n=%h sclk=%b busy=%b, want ff 0 0", bus1.cs_n, bus1.sclk, bus1.busy);
    end
    $display("txn reset: idle held for 50 cycles");
  endtask

  task automatic test_basic_read();
    logic [7:0] exp_d [0:4];
    logic [7:0] cmd;
    int         done_n, cs_bad, nstb;
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) slv_data[i] = exp_d[i];
    run_txn(8'h04, 8'h8A, -1, done_n, cmd, cs_bad, nstb);
    vectors++;
    if (done_n !== 393) begin
      miscompares++;
      $display("FAIL basic_done_cycle: got %0d (0 = none within 600), want 393", done_n);
    end
    vectors++;
    if ({bus.cs_n, bus.busy} !== {8'hFF, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_fin: cs_n=%h busy=%b, want ff 0", bus.cs_n, bus.busy);
    end
    vectors++;
    if (cmd !== 8'h8A) begin
      miscompares++;
      $display("FAIL basic_mosi_cmd: got %h, want 8a", cmd);
    end
    vectors++;
    if (cs_bad !== 0) begin
      miscompares++;
      $display("FAIL basic_cs_n: %0d busy cycles with cs_n != fb, want 0", cs_bad);
    end
    vectors++;
    if (nstb !== 5) begin
      miscompares++;
      $display("FAIL basic_strobe_count: got %0d, want 5", nstb);
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({cap_addr[i], cap_data[i]} !== {5'(3 + i), exp_d[i]}) begin
        miscompares++;
        $display("FAIL basic_strobe_%0d: addr=%0d data=%h, want addr=%0d data=%h",
                 i, cap_addr[i], cap_data[i], 3 + i, exp_d[i]);
      end
    end
    vectors++;
    if ({bus.spi_select, bus.spi_reg} !== {8'h04, 8'h8A}) begin
      miscompares++;
      $display("FAIL basic_latched: spi_select=%h spi_reg=%h, want 04 8a", bus.spi_select, bus.spi_reg);
    end
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done_width: done=%b one cycle later, want 0", bus.done);
    end
    $display("txn basic_read: done at cycle %0d, %0d strobes", done_n, nstb);
  endtask

  task automatic test_bad_select();
    logic [7:0] bad_sel [0:1];
    int         activity;
    bad_sel = '{8'h00, 8'h06};
    for (int t = 0; t < 2; t++) begin
      activity = 0;
      @(negedge clk);
      bus.spi_select_in = bad_sel[t];
      bus.spi_reg_in    = 8'h3C;
      bus.start         = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      vectors++;
      if ({bus.err_sel, bus.cs_n, bus.busy} !== {1'b1, 8'hFF, 1'b0}) begin
        miscompares++;
        $display("FAIL bad_sel_%h: err_sel=%b cs_n=%h busy=%b, want 1 ff 0",
                 bad_sel[t], bus.err_sel, bus.cs_n, bus.busy);
      end
      @(negedge clk);
      vectors++;
      if (bus.err_sel !== 1'b0) begin
        miscompares++;
        $display("FAIL bad_sel_pulse_%h: err_sel=%b one cycle later, want 0", bad_sel[t], bus.err_sel);
      end
      for (int i = 0; i < 20; i++) begin
        if (bus.buffer_en !== 1'b0 || bus.sclk !== 1'b0 || bus.busy !== 1'b0 || bus.cs_n !== 8'hFF) activity++;
        @(negedge clk);
      end
      vectors++;
      if (activity !== 0) begin
        miscompares++;
        $display("FAIL bad_sel_quiet_%h: %0d active cycles, want 0", bad_sel[t], activity);
      end
      $display("txn bad_select %h: rejected", bad_sel[t]);
    end
  endtask

  task automatic test_busy_start();
    logic [7:0] exp_d [0:4];
    logic [7:0] cmd;
    int         done_n, cs_bad, nstb;
    exp_d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    for (int i = 0; i < 5; i++) slv_data[i] = exp_d[i];
    run_txn(8'h04, 8'h8A, 100, done_n, cmd, cs_bad, nstb);
    vectors++;
    if (cs_bad !== 0 || nstb !== 5 || done_n !== 393) begin
      miscompares++;
      $display("FAIL busy_start_ignored: cs_bad=%0d strobes=%0d done_cycle=%0d, want 0 5 393",
               cs_bad, nstb, done_n);
    end
    vectors++;
    if ({cap_data[0], cap_data[4], cap_addr[4]} !== {8'hAA, 8'hEE, 5'd7}) begin
      miscompares++;
      $display("FAIL busy_start_data: first=%h last=%h last_addr=%0d, want aa ee 7",
               cap_data[0], cap_data[4], cap_addr[4]);
    end
    vectors++;
    if ({bus.spi_select, bus.spi_reg} !== {8'h04, 8'h8A}) begin
      miscompares++;
      $display("FAIL busy_start_latched: spi_select=%h spi_reg=%h, want 04 8a", bus.spi_select, bus.spi_reg);
    end
    // Start presented during the done cycle must not launch a new transaction.
    bus.spi_select_in = 8'h01;
    bus.spi_reg_in    = 8'h55;
    bus.start         = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.busy, bus.cs_n, bus.err_sel} !== {1'b0, 8'hFF, 1'b0}) begin
      miscompares++;
      $display("FAIL fin_start_ignored: busy=%b cs_n=%h err_sel=%b, want 0 ff 0", bus.busy, bus.cs_n, bus.err_sel);
    end
    $display("txn busy_start: done at cycle %0d, %0d strobes", done_n, nstb);
  endtask

  task automatic test_reset_mid();
    int nstb = 0;
    int n = 0;
    int late = 0;
    for (int i = 0; i < 5; i++) slv_data[i] = 8'h61 + 8'(i);
    @(negedge clk);
    bus.spi_select_in = 8'h04;
    bus.spi_reg_in    = 8'h8A;
    bus.start         = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (nstb < 2 && n < 600) begin
      if (bus.buffer_en === 1'b1) nstb++;
      if (nstb < 2) begin
        @(negedge clk);
        n++;
      end
    end
    vectors++;
    if (nstb !== 2) begin
      miscompares++;
      $display("FAIL reset_mid_wait: saw %0d strobes within 600 cycles, want 2", nstb);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({bus.cs_n, bus.sclk, bus.busy} !== {8'hFF, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid_abort: cs_n=%h sclk=%b busy=%b, want ff 0 0", bus.cs_n, bus.sclk, bus.busy);
    end
    for (int i = 0; i < 500; i++) begin
      if (bus.buffer_en !== 1'b0 || bus.done !== 1'b0) late++;
      @(negedge clk);
    end
    vectors++;
    if (late !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: %0d cycles with buffer_en or done, want 0", late);
    end
    $display("txn reset_mid: aborted after %0d strobes", nstb);
  endtask

  task automatic test_timing_n1();
    int         n = 1;
    int         done_n = 0;
    int         run = 0;
    int         transitions = 0;
    int         halves = 0;
    int         bad_half = 0;
    int         unstable = 0;
    int         high_idle = 0;
    int         nstb = 0;
    int         rises = 0;
    logic       prev_sclk = 1'b0;
    logic       prev_mosi = 1'b0;
    logic [7:0] cmd = 8'h00;
    logic [4:0] s_addr = 5'd0;
    logic [7:0] s_data = 8'h00;
    slv1_data = 8'hC3;
    @(negedge clk);
    bus1.spi_select_in = 8'h02;
    bus1.spi_reg_in    = 8'h5A;
    bus1.start         = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    while (done_n == 0 && n <= 300) begin
      if (bus1.done === 1'b1) begin
        done_n = n;
      end else begin
        if (bus1.sclk === 1'b1 && bus1.cs_n === 8'hFF) high_idle++;
        if (bus1.sclk !== prev_sclk) begin
          if (transitions > 0) begin
            halves++;
            if (run != 4) bad_half++;
          end
          transitions++;
          run = 1;
          if (bus1.sclk === 1'b1) begin
            if (bus1.mosi !== prev_mosi) unstable++;
            if (rises < 8) cmd = {cmd[6:0], bus1.mosi};
            rises++;
          end
        end else begin
          run++;
        end
        if (bus1.buffer_en === 1'b1) begin
          nstb++;
          s_addr = bus1.addr;
          s_data = bus1.data_rec_out;
        end
        prev_sclk = bus1.sclk;
        prev_mosi = bus1.mosi;
        @(negedge clk);
        n++;
      end
    end
    vectors++;
    if (done_n !== 137) begin
      miscompares++;
      $display("FAIL n1_done_cycle: got %0d (0 = none within 300), want 137", done_n);
    end
    vectors++;
    if (halves !== 31 || bad_half !== 0) begin
      miscompares++;
      $display("FAIL n1_half_period: %0d inner half-periods, %0d not 4 cycles, want 31 and 0", halves, bad_half);
    end
    vectors++;
    if (unstable !== 0 || high_idle !== 0) begin
      miscompares++;
      $display("FAIL n1_mosi_sclk: mosi changed at %0d rises, sclk high with cs idle %0d cycles, want 0 0",
               unstable, high_idle);
    end
    vectors++;
    if (cmd !== 8'h5A) begin
      miscompares++;
      $display("FAIL n1_mosi_cmd: got %h, want 5a", cmd);
    end
    vectors++;
    if ({nstb, s_addr, s_data} !== {32'd1, 5'd3, 8'hC3}) begin
      miscompares++;
      $display("FAIL n1_strobe: count=%0d addr=%0d data=%h, want 1 3 c3", nstb, s_addr, s_data);
    end
    $display("txn timing_n1: done at cycle %0d, %0d half-periods", done_n, halves);
  endtask

  initial begin
    bus.start          = 1'b0;
    bus.spi_select_in  = 8'h00;
    bus.spi_reg_in     = 8'h00;
    bus1.start         = 1'b0;
    bus1.spi_select_in = 8'h00;
    bus1.spi_reg_in    = 8'h00;
    for (int i = 0; i < 5; i++) slv_data[i] = 8'h00;
    slv1_data = 8'h00;
    test_reset();
    test_basic_read();
    test_bad_select();
    test_busy_start();
    test_reset_mid();
    test_timing_n1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
